// File: rtl/operation_caller_16.sv
// Initiator for the ST/RD/RES handshake: runs a downstream operation CNT times, feeding each result back as argument 0.
// Optional watchdog per wait state is enabled by defining OPERATION_CALLER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a new start, RES/ERR hold the last run's outcome
// ISSUE | OP_ST high, waiting for the downstream block to drop OP_RD
// BUSY  | OP_ST low, waiting for the downstream block to raise OP_RD
module operation_caller_16 #(
    parameter int BW        = 16,
    parameter int CW        = 8,
    parameter int TO_CYCLES = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ST,
    output logic          RD,
    output logic [BW-1:0] RES,
    output logic          ERR,
    input  logic [BW-1:0] IN0,
    input  logic [BW-1:0] IN1,
    input  logic [CW-1:0] CNT,
    output logic          OP_ST,
    input  logic          OP_RD,
    input  logic [BW-1:0] OP_RES,
    output logic [BW-1:0] OP_A0,
    output logic [BW-1:0] OP_A1,
    output logic [BW-1:0] OP_A2
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;

    logic [1:0]    state;
    logic          st_q;
    logic          st_rise;
    logic [BW-1:0] acc;
    logic [BW-1:0] arg1;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] idx;
    logic [CW-1:0] idx_nxt;
    logic          wait_done;
    logic          timeout;

    // Edge register runs through reset so a start held across release is not seen as new.
    always_ff @(posedge CLK) begin
        st_q <= ST;
    end

    assign st_rise   = ST & ~st_q;
    assign idx_nxt   = idx + 1'b1;
    assign wait_done = ((state == ISSUE) && !OP_RD) || ((state == BUSY) && OP_RD);

    assign OP_A0 = acc;
    assign OP_A1 = arg1;
    assign OP_A2 = BW'(idx);

`ifdef OPERATION_CALLER_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);

    logic [TW-1:0] tmr;

    // Down-counter reloads in IDLE and on every wait completion, so it restarts on each ISSUE/BUSY entry.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            tmr <= TW'(TO_CYCLES - 1);
        end else if ((state == IDLE) || wait_done) begin
            tmr <= TW'(TO_CYCLES - 1);
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    assign timeout = ((state == ISSUE) || (state == BUSY)) && !wait_done && (tmr == '0);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ERR <= 1'b0;
        end else if ((state == IDLE) && st_rise) begin
            ERR <= 1'b0;
        end else if (timeout) begin
            ERR <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign ERR     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            RD    <= 1'b1;
            RES   <= '0;
            OP_ST <= 1'b0;
            acc   <= '0;
            arg1  <= '0;
            cnt_q <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (st_rise) begin
                        acc   <= IN0;
                        arg1  <= IN1;
                        cnt_q <= CNT;
                        idx   <= '0;
                        if (CNT == '0) begin
                            RES <= IN0;
                        end else begin
                            RD    <= 1'b0;
                            OP_ST <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (wait_done) begin
                        OP_ST <= 1'b0;
                        state <= BUSY;
                    end else if (timeout) begin
                        OP_ST <= 1'b0;
                        RES   <= '1;
                        RD    <= 1'b1;
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (wait_done) begin
                        acc <= OP_RES;
                        idx <= idx_nxt;
                        if (idx_nxt == cnt_q) begin
                            RES   <= OP_RES;
                            RD    <= 1'b1;
                            state <= IDLE;
                        end else begin
                            OP_ST <= 1'b1;
                            state <= ISSUE;
                        end
                    end else if (timeout) begin
                        RES   <= '1;
                        RD    <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    OP_ST <= 1'b0;
                    RD    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operation_caller_16.sv
// Bench for operation_caller_16 with a two-cycle downstream responder and an expected-result queue.
// Timeout scenario is compiled in only when OPERATION_CALLER_TIMEOUT_EN is defined.
module tb_operation_caller_16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st = 1'b0;
    logic        rd;
    logic [15:0] res;
    logic        err;
    logic [15:0] in0 = '0;
    logic [15:0] in1 = '0;
    logic [7:0]  cnt = '0;
    logic        op_st;
    logic        op_rd = 1'b1;
    logic [15:0] op_res = '0;
    logic [15:0] op_a0;
    logic [15:0] op_a1;
    logic [15:0] op_a2;

    int errors = 0;
    int checks = 0;

    // responder mode: 0 returns A0+A2, 1 returns A0+1, 2 never acknowledges
    int          mode = 0;
    int          edges = 0;
    logic        op_st_q = 1'b0;
    logic [15:0] a2_seen[$];
    logic [15:0] exp_q[$];

    operation_caller_16 dut (
        .CLK(clk), .RST(rst), .ST(st), .RD(rd), .RES(res), .ERR(err),
        .IN0(in0), .IN1(in1), .CNT(cnt),
        .OP_ST(op_st), .OP_RD(op_rd), .OP_RES(op_res),
        .OP_A0(op_a0), .OP_A1(op_a1), .OP_A2(op_a2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        op_st_q <= op_st;
        if (op_st && !op_st_q) begin
            edges <= edges + 1;
            a2_seen.push_back(op_a2);
            if (mode != 2) op_rd <= 1'b0;
        end else if (!op_rd) begin
            op_rd  <= 1'b1;
            op_res <= (mode == 1) ? op_a0 + 16'd1 : op_a0 + op_a2;
        end
    end

    function automatic logic [15:0] model(input logic [15:0] seed, input int n, input int m);
        logic [15:0] a;
        a = seed;
        for (int i = 0; i < n; i++) a = (m == 1) ? a + 16'd1 : a + 16'(i);
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a run, optionally re-pulses ST mid-run, waits for RD and scores RES.
    task automatic run(input logic [15:0] s0, input logic [15:0] s1, input logic [7:0] n,
                       input logic [15:0] expv, input int repulse_at, output int low);
        exp_q.push_back(expv);
        in0 = s0; in1 = s1; cnt = n;
        st = 1'b1;
        tick();
        st = 1'b0;
        low = 0;
        while (rd === 1'b0 && low < 2000) begin
            st = (low == repulse_at) ? 1'b1 : 1'b0;
            tick();
            low++;
        end
        st = 1'b0;
        checks++;
        if (low >= 2000) begin
            errors++;
            $display("FAIL run_wait: RD still %b after %0d cycles, required 1", rd, low);
        end
        begin
            logic [15:0] e;
            e = exp_q.pop_front();
            checks++;
            if (res !== e) begin
                errors++;
                $display("FAIL run_res: got %h, required %h", res, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks += 7;
        if (rd !== 1'b1)      begin errors++; $display("FAIL reset_rd: got %b, required 1", rd); end
        if (res !== 16'h0)    begin errors++; $display("FAIL reset_res: got %h, required 0000", res); end
        if (err !== 1'b0)     begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
        if (op_st !== 1'b0)   begin errors++; $display("FAIL reset_op_st: got %b, required 0", op_st); end
        if (op_a0 !== 16'h0)  begin errors++; $display("FAIL reset_a0: got %h, required 0000", op_a0); end
        if (op_a1 !== 16'h0)  begin errors++; $display("FAIL reset_a1: got %h, required 0000", op_a1); end
        if (op_a2 !== 16'h0)  begin errors++; $display("FAIL reset_a2: got %h, required 0000", op_a2); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_cnt_zero();
        int low;
        int e0;
        bit dropped;
        e0 = edges;
        run(16'd7, 16'd0, 8'd0, 16'd7, -1, low);
        dropped = 1'b0;
        repeat (4) begin
            if (rd !== 1'b1) dropped = 1'b1;
            tick();
        end
        checks += 3;
        if (low != 0)      begin errors++; $display("FAIL zero_low: RD low %0d cycles, required 0", low); end
        if (dropped)       begin errors++; $display("FAIL zero_rd: RD dropped=1, required 0"); end
        if (edges != e0)   begin errors++; $display("FAIL zero_calls: %0d calls, required 0", edges - e0); end
    endtask

    task automatic test_run4();
        int low;
        a2_seen.delete();
        run(16'd10, 16'd3, 8'd4, model(16'd10, 4, 0), -1, low);
        checks += 4;
        if (low != 12)          begin errors++; $display("FAIL run4_low: RD low %0d cycles, required 12", low); end
        if (err !== 1'b0)       begin errors++; $display("FAIL run4_err: got %b, required 0", err); end
        if (op_a1 !== 16'd3)    begin errors++; $display("FAIL run4_a1: got %h, required 0003", op_a1); end
        if (a2_seen.size() != 4) begin errors++; $display("FAIL run4_ncalls: got %0d, required 4", a2_seen.size()); end
        for (int i = 0; i < 4 && i < a2_seen.size(); i++) begin
            checks++;
            if (a2_seen[i] !== 16'(i)) begin
                errors++;
                $display("FAIL run4_a2: call %0d index %h, required %h", i, a2_seen[i], 16'(i));
            end
        end
    endtask

    task automatic test_wrap();
        int low;
        mode = 1;
        run(16'hFFFF, 16'd0, 8'd1, 16'h0000, -1, low);
        mode = 0;
        checks += 2;
        if (err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b, required 0", err); end
        if (low != 3)     begin errors++; $display("FAIL wrap_low: RD low %0d cycles, required 3", low); end
    endtask

    task automatic test_repulse();
        int low;
        int e0;
        e0 = edges;
        run(16'd10, 16'd0, 8'd4, 16'd16, 2, low);
        checks += 2;
        if (edges - e0 != 4) begin errors++; $display("FAIL repulse_calls: %0d calls, required 4", edges - e0); end
        if (low != 12)       begin errors++; $display("FAIL repulse_low: RD low %0d cycles, required 12", low); end
    endtask

    task automatic test_reset_mid();
        int e0;
        bit started;
        in0 = 16'd10; cnt = 8'd4;
        st = 1'b1;
        tick();
        st = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        st = 1'b1;
        tick();
        checks += 4;
        if (rd !== 1'b1)    begin errors++; $display("FAIL midrst_rd: got %b, required 1", rd); end
        if (op_st !== 1'b0) begin errors++; $display("FAIL midrst_op_st: got %b, required 0", op_st); end
        if (res !== 16'h0)  begin errors++; $display("FAIL midrst_res: got %h, required 0000", res); end
        if (op_a0 !== 16'h0) begin errors++; $display("FAIL midrst_a0: got %h, required 0000", op_a0); end
        tick();
        rst = 1'b1;
        e0 = edges;
        started = 1'b0;
        repeat (6) begin
            tick();
            if (rd !== 1'b1) started = 1'b1;
        end
        st = 1'b0;
        checks += 2;
        if (started)     begin errors++; $display("FAIL midrst_held_st: run started=1, required 0"); end
        if (edges != e0) begin errors++; $display("FAIL midrst_calls: %0d calls, required 0", edges - e0); end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        int low;
        logic [15:0] s;
        int n;
        for (int k = 0; k < 4; k++) begin
            s = 16'($urandom);
            n = $urandom_range(1, 6);
            run(s, 16'($urandom), 8'(n), model(s, n, 0), -1, low);
            checks++;
            if (low != 3 * n) begin
                errors++;
                $display("FAIL b2b_low: run %0d RD low %0d cycles, required %0d", k, low, 3 * n);
            end
        end
    endtask

`ifdef OPERATION_CALLER_TIMEOUT_EN
    task automatic test_timeout();
        int low;
        mode = 2;
        run(16'd5, 16'd0, 8'd2, 16'hFFFF, -1, low);
        checks += 2;
        if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b, required 1", err); end
        if (low != 255)   begin errors++; $display("FAIL to_low: RD low %0d cycles, required 255", low); end
        mode = 0;
        tick();
        run(16'd1, 16'd0, 8'd2, model(16'd1, 2, 0), -1, low);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b, required 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_cnt_zero();
        test_run4();
        test_wrap();
        test_repulse();
        test_reset_mid();
        test_back_to_back();
`ifdef OPERATION_CALLER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
